pea_fire_scheduler: RTL and testbench
=====================================

# pea_fire_scheduler

Self-timed CFDF scheduler for the polynomial evaluation accelerator (PEA) actor. It sits between the `PEA_enable` check and `PEA_top_module_1`, replacing the bench-driven invoke sequence. On each step it:
- presents the current mode on `next_instr`;
- samples `enable` and pulses `invoke`;
- waits for firing complete (`FC`);
- latches the actor's next mode and counts the firing.

It stops on a firing limit, a watchdog timeout or an illegal mode.

## Interface
Parameters:
- `CW`, 16 — width of firing counter and limit.
- `TIMEOUT`, 64 — max cycles in WAIT_FC before watchdog trips (≥2).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; high = schedule firings.
- `fire_limit`  in  CW  firings to perform; 0 = unlimited. Sampled on IDLE→CHECK.
- `enable`  in  1  combinational enable from `PEA_enable` for the mode on `next_instr`.
- `FC`  in  1  firing complete from actor; level or pulse.
- `next_mode_in`  in  2  actor's next-mode output (`next_mode_out`), valid when FC rises.
- `invoke`  out  1  one-cycle invoke pulse to actor.
- `next_instr`  out  2  current mode: SETUP_INSTR=00, INSTR=01, OUTPUT=10.
- `busy`  out  1  high in CHECK, INVOKE, WAIT_FC, UPDATE.
- `done`  out  1  high in DONE.
- `err_timeout`  out  1  sticky watchdog error.
- `err_mode`  out  1  sticky illegal-mode (2'b11) error.
- `fire_count`  out  CW  completed firings since leaving IDLE.

## Operation
States: IDLE, CHECK, INVOKE, WAIT_FC, UPDATE, DONE, HALT.

Transitions:
- **IDLE**
  - `run`=1 → CHECK. Latch `fire_limit`, clear `fire_count`.
  - `next_instr` keeps its last value. It is SETUP_INSTR after reset.
- **CHECK**
  - `run`=0 → IDLE.
  - Else `enable`=1 → INVOKE.
  - Else stay in CHECK. No invoke is issued and no error is raised while disabled.
- **INVOKE**
  - `invoke`=1 for exactly this cycle. Then → WAIT_FC.
- **WAIT_FC**
  - Completion (FC rising edge, see below) → UPDATE.
  - Watchdog reaches TIMEOUT cycles → HALT, set `err_timeout`.
  - `run` is ignored here. A firing in progress is never aborted.
- **UPDATE**
  - `next_mode_in`==11 → HALT, set `err_mode`. Mode and count are unchanged.
  - Else: `next_instr`←`next_mode_in`, `fire_count`+1.
  - Then → DONE if the limit is nonzero and the new count equals the limit; else → CHECK.
- **DONE**
  - Hold `done`=1. `run`=0 → IDLE.
- **HALT**
  - Absorbing. Exit only via reset.

Completion detection:
- A rising edge of `FC` (FC & ~fc_q) is captured into a pending flag during INVOKE or WAIT_FC. This tolerates an actor raising FC in the invoke cycle.
- The flag is cleared on entering UPDATE.
- A level-held `FC` is therefore counted once per firing.
- An `FC` edge in any other state is ignored.

Arithmetic and errors:
- `fire_count` wraps modulo 2^CW when the limit is 0.
- The watchdog counter clears on entering WAIT_FC and increments each WAIT_FC cycle.
- Errors are reported via sticky flags only.

## Timing
- Reset (async assert, sync deassert at the top level) sets: state IDLE, `invoke`=0, `next_instr`=00, `busy`=0, `done`=0, `err_timeout`=0, `err_mode`=0, `fire_count`=0, watchdog=0.
- Reset mid-firing takes effect immediately with the same values. The actor must be reset alongside.
- `run` rising edge → CHECK next cycle. `invoke` is high in the cycle after `enable` is sampled high in CHECK.
- Minimum firing period is 4 cycles (CHECK, INVOKE, WAIT_FC, UPDATE). This requires the FC edge no later than the first WAIT_FC cycle.
- `next_instr` and `fire_count` update on the UPDATE→next edge. `enable` reflects the new mode in the following CHECK.
- Timeout: with FC never rising, HALT is entered TIMEOUT cycles after WAIT_FC entry.

## Structure
- Shared package `pea_pkg` holds:
  - mode constants SETUP_INSTR, INSTR, OUTPUT and ILLEGAL=2'b11;
  - the scheduler state encoding;
  - the 2-bit mode typedef.
  
  Both `PEA_enable` and `PEA_top_module_1` reuse the same constants.
- One natural sub-module: `pea_watchdog`, a clearable TIMEOUT counter with an expiry output.
- FC edge detection and pending flag stay inline.

## Test plan
- **Normal run.** Reset, limit=3, `run`=1, `enable`=1, actor FC 2 cycles after invoke, modes 01,10,00.
  - Expect exactly 3 invoke pulses.
  - `next_instr` sequence 00→01→10→00.
  - `fire_count`=3, `done`=1.
- **Stall.** `enable`=0 for 10 cycles, then 1.
  - No `invoke` while disabled.
  - `invoke` exactly 1 cycle after `enable` rises.
  - No errors.
- **Level FC.** FC held high for 5 cycles per firing, limit=2.
  - `fire_count` increments by exactly 1 per firing.
  - `done` after 2 firings.
- **Timeout.** TIMEOUT=8, FC never rises.
  - `err_timeout`=1 exactly 8 cycles after WAIT_FC entry.
  - State HALT, `busy`=0.
  - Only reset clears it.
- **Illegal mode.** `next_mode_in`=11 at completion.
  - `err_mode`=1, `next_instr` unchanged, `fire_count` unchanged.
- **Run drop and reset.**
  - `run` dropped in WAIT_FC: firing completes, `fire_count`+1, then IDLE.
  - `rst` asserted mid-WAIT_FC: all outputs return to reset values immediately.

Source files
------------

// File: rtl/pea_pkg.sv
// Shared definitions for the polynomial evaluation accelerator (PEA):
// mode encoding used by the enable check, the actor and the fire scheduler,
// plus the scheduler state encoding.
package pea_pkg;

    // Two-bit actor mode carried on next_instr / next_mode_out
    typedef logic [1:0] pea_mode_t;

    localparam pea_mode_t SETUP_INSTR = 2'b00;
    localparam pea_mode_t INSTR       = 2'b01;
    localparam pea_mode_t OUTPUT      = 2'b10;
    localparam pea_mode_t ILLEGAL     = 2'b11;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_INVOKE  = 3'd2,
        ST_WAIT_FC = 3'd3,
        ST_UPDATE  = 3'd4,
        ST_DONE    = 3'd5,
        ST_HALT    = 3'd6
    } sched_state_t;

    // True for any mode the actor is able to execute
    function automatic logic mode_is_legal(input pea_mode_t mode);
        return (mode != ILLEGAL);
    endfunction

endpackage

// File: rtl/pea_watchdog.sv
// Clearable cycle counter that flags expiry after TIMEOUT counted cycles.
// The count sits at TIMEOUT-1 on the last allowed cycle, so the owner can
// leave its waiting state exactly TIMEOUT cycles after clearing it.
module pea_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] count_r;

    // Cycle counter: clear has priority, holds once the last cycle is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WW{1'b0}};
        end else if (clr) begin
            count_r <= {WW{1'b0}};
        end else if (inc && (count_r != LAST)) begin
            count_r <= count_r + WW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/pea_fire_scheduler.sv
// Self-timed CFDF scheduler for the PEA actor: checks enable for the current
// mode, pulses invoke, waits for firing complete, then adopts the actor's
// next mode and counts the firing. Stops on a firing limit, a watchdog
// timeout or an illegal next mode.
module pea_fire_scheduler
    import pea_pkg::*;
#(
    parameter int CW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [CW-1:0] fire_limit,
    input  logic          enable,
    input  logic          FC,
    input  logic [1:0]    next_mode_in,
    output logic          invoke,
    output logic [1:0]    next_instr,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          err_mode,
    output logic [CW-1:0] fire_count
);

    sched_state_t  state_r;
    logic [CW-1:0] limit_r;
    logic [CW-1:0] fire_count_r;
    pea_mode_t     next_instr_r;
    logic          invoke_r;
    logic          busy_r;
    logic          done_r;
    logic          err_timeout_r;
    logic          err_mode_r;
    logic          fc_q_r;
    logic          fc_pend_r;

    logic          fc_rise_s;
    logic          fc_done_s;
    logic          wd_clr_s;
    logic          wd_inc_s;
    logic          wd_expired_s;
    logic [CW-1:0] count_inc_s;
    logic          limit_hit_s;

    // A rising FC in the last WAIT_FC cycle still counts, so completion
    // looks at both the captured flag and the live edge.
    assign fc_rise_s   = FC & ~fc_q_r;
    assign fc_done_s   = fc_pend_r | fc_rise_s;
    assign wd_clr_s    = (state_r == ST_INVOKE);
    assign wd_inc_s    = (state_r == ST_WAIT_FC);
    assign count_inc_s = fire_count_r + CW'(1);
    assign limit_hit_s = (limit_r != {CW{1'b0}}) && (count_inc_s == limit_r);

    pea_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (wd_clr_s),
        .inc     (wd_inc_s),
        .expired (wd_expired_s)
    );

    // FC edge capture: pending flag armed only while a firing is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc_q_r    <= 1'b0;
            fc_pend_r <= 1'b0;
        end else begin
            fc_q_r <= FC;
            if ((state_r == ST_WAIT_FC) && fc_done_s) begin
                fc_pend_r <= 1'b0;
            end else if (((state_r == ST_INVOKE) || (state_r == ST_WAIT_FC)) && fc_rise_s) begin
                fc_pend_r <= 1'b1;
            end else begin
                fc_pend_r <= fc_pend_r;
            end
        end
    end

    // Scheduler FSM with registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            limit_r       <= {CW{1'b0}};
            fire_count_r  <= {CW{1'b0}};
            next_instr_r  <= SETUP_INSTR;
            invoke_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_timeout_r <= 1'b0;
            err_mode_r    <= 1'b0;
        end else begin
            invoke_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (run) begin
                        state_r      <= ST_CHECK;
                        limit_r      <= fire_limit;
                        fire_count_r <= {CW{1'b0}};
                        busy_r       <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (!run) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (enable) begin
                        state_r  <= ST_INVOKE;
                        invoke_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                ST_INVOKE: begin
                    state_r <= ST_WAIT_FC;
                    busy_r  <= 1'b1;
                end
                ST_WAIT_FC: begin
                    if (fc_done_s) begin
                        state_r <= ST_UPDATE;
                        busy_r  <= 1'b1;
                    end else if (wd_expired_s) begin
                        state_r       <= ST_HALT;
                        busy_r        <= 1'b0;
                        err_timeout_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (!mode_is_legal(next_mode_in)) begin
                        state_r    <= ST_HALT;
                        busy_r     <= 1'b0;
                        err_mode_r <= 1'b1;
                    end else begin
                        next_instr_r <= next_mode_in;
                        fire_count_r <= count_inc_s;
                        if (limit_hit_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_CHECK;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    if (!run) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end else begin
                        done_r <= 1'b1;
                    end
                end
                ST_HALT: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign invoke      = invoke_r;
    assign next_instr  = next_instr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_timeout = err_timeout_r;
    assign err_mode    = err_mode_r;
    assign fire_count  = fire_count_r;

endmodule

// File: tb/tb_pea_fire_scheduler.sv
// Directed bench for pea_fire_scheduler with a small actor model that
// answers each invoke with FC after a programmable delay and hold time.
module tb_pea_fire_scheduler;
    import pea_pkg::*;

    localparam int CW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [CW-1:0] fire_limit;
    logic          enable;
    logic          FC;
    logic [1:0]    next_mode_in;
    logic          invoke;
    logic [1:0]    next_instr;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_mode;
    logic [CW-1:0] fire_count;

    always #5 clk = ~clk;

    pea_fire_scheduler #(.CW(CW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .fire_limit   (fire_limit),
        .enable       (enable),
        .FC           (FC),
        .next_mode_in (next_mode_in),
        .invoke       (invoke),
        .next_instr   (next_instr),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .err_mode     (err_mode),
        .fire_count   (fire_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // actor model state
    logic       actor_on;
    int         a_d;
    int         a_h;
    int         a_dly;
    int         a_hold;
    logic [1:0] mode_tab [0:15];
    int         mode_idx;

    initial begin
        FC = 1'b0;
        next_mode_in = 2'b00;
        a_dly = 0;
        a_hold = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                FC = 1'b0;
                a_dly = 0;
                a_hold = 0;
            end else begin
                if (a_hold > 0) begin
                    a_hold--;
                    if (a_hold == 0) FC = 1'b0;
                end
                if (a_dly > 0) begin
                    a_dly--;
                    if (a_dly == 0) begin
                        FC = 1'b1;
                        a_hold = a_h;
                        next_mode_in = mode_tab[mode_idx];
                        mode_idx++;
                    end
                end
                if (invoke === 1'b1 && actor_on) a_dly = a_d;
            end
        end
    end

    // invoke monitor: records mode and count seen at each invoke pulse
    int            inv_cnt = 0;
    logic [1:0]    inv_mode [0:63];
    logic [CW-1:0] inv_fc   [0:63];

    initial begin
        forever begin
            @(negedge clk);
            if (invoke === 1'b1 && inv_cnt < 64) begin
                inv_mode[inv_cnt] = next_instr;
                inv_fc[inv_cnt]   = fire_count;
                inv_cnt++;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_invoke(input string tag, input int max_cyc);
        int start;
        int k;
        start = inv_cnt;
        k = 0;
        while (inv_cnt == start && k < max_cyc) begin
            step(1);
            k++;
        end
        chk({tag, "_invoke_seen"}, 32'(inv_cnt > start), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int k;
        k = 0;
        while (done !== 1'b1 && k < max_cyc) begin
            step(1);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_invoke"},      32'(invoke),      32'd0);
        chk({tag, "_next_instr"},  32'(next_instr),  32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_done"},        32'(done),        32'd0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        chk({tag, "_err_mode"},    32'(err_mode),    32'd0);
        chk({tag, "_fire_count"},  32'(fire_count),  32'd0);
    endtask

    int base;

    initial begin
        rst = 1'b0;
        run = 1'b0;
        enable = 1'b0;
        fire_limit = 16'd0;
        actor_on = 1'b1;
        a_d = 2;
        a_h = 1;
        mode_idx = 0;
        for (int i = 0; i < 16; i++) mode_tab[i] = 2'b00;
        step(3);
        chk_reset_vals("rst0");
        rst = 1'b1;
        step(2);

        // normal run: limit 3, modes 01,10,00
        mode_tab[0] = 2'b01; mode_tab[1] = 2'b10; mode_tab[2] = 2'b00; mode_idx = 0;
        a_d = 2; a_h = 1;
        fire_limit = 16'd3;
        enable = 1'b1;
        run = 1'b1;
        base = inv_cnt;
        step(1);
        chk("norm_busy_check", 32'(busy), 32'd1);
        wait_done("norm", 60);
        chk("norm_invokes",    32'(inv_cnt - base),  32'd3);
        chk("norm_mode0",      32'(inv_mode[base]),     32'd0);
        chk("norm_mode1",      32'(inv_mode[base + 1]), 32'd1);
        chk("norm_mode2",      32'(inv_mode[base + 2]), 32'd2);
        chk("norm_next_instr", 32'(next_instr), 32'd0);
        chk("norm_fire_count", 32'(fire_count), 32'd3);
        chk("norm_busy_done",  32'(busy),       32'd0);
        step(5);
        chk("norm_hold_done",  32'(done),            32'd1);
        chk("norm_no_extra",   32'(inv_cnt - base),  32'd3);
        run = 1'b0;
        step(2);
        chk("norm_idle_done",  32'(done), 32'd0);

        // stall: enable low 10 cycles, then high
        mode_tab[0] = 2'b01; mode_idx = 0;
        fire_limit = 16'd1;
        enable = 1'b0;
        run = 1'b1;
        base = inv_cnt;
        step(10);
        chk("stall_no_invoke", 32'(inv_cnt - base), 32'd0);
        chk("stall_busy",      32'(busy),           32'd1);
        chk("stall_no_err",    32'({err_timeout, err_mode}), 32'd0);
        enable = 1'b1;
        step(1);
        chk("stall_invoke_now", 32'(invoke),          32'd1);
        chk("stall_one_inv",    32'(inv_cnt - base),  32'd1);
        step(1);
        chk("stall_invoke_1cyc", 32'(invoke), 32'd0);
        wait_done("stall", 40);
        chk("stall_fire_count", 32'(fire_count), 32'd1);
        chk("stall_next_instr", 32'(next_instr), 32'd1);
        chk("stall_err_after",  32'({err_timeout, err_mode}), 32'd0);
        run = 1'b0;
        step(2);

        // level FC: held 5 cycles per firing, limit 2
        mode_tab[0] = 2'b10; mode_tab[1] = 2'b00; mode_idx = 0;
        a_d = 3; a_h = 5;
        fire_limit = 16'd2;
        run = 1'b1;
        base = inv_cnt;
        wait_done("level", 60);
        chk("level_invokes",   32'(inv_cnt - base),     32'd2);
        chk("level_fc_at_1",   32'(inv_fc[base]),       32'd0);
        chk("level_fc_at_2",   32'(inv_fc[base + 1]),   32'd1);
        chk("level_fire_count", 32'(fire_count),        32'd2);
        chk("level_next_instr", 32'(next_instr),        32'd0);
        step(8);
        chk("level_count_hold", 32'(fire_count), 32'd2);
        run = 1'b0;
        step(2);

        // illegal mode on second completion
        mode_tab[0] = 2'b01; mode_tab[1] = 2'b11; mode_idx = 0;
        a_d = 2; a_h = 1;
        fire_limit = 16'd0;
        run = 1'b1;
        base = inv_cnt;
        step(20);
        chk("ill_err_mode",    32'(err_mode),        32'd1);
        chk("ill_next_instr",  32'(next_instr),      32'd1);
        chk("ill_fire_count",  32'(fire_count),      32'd1);
        chk("ill_busy",        32'(busy),            32'd0);
        chk("ill_err_timeout", 32'(err_timeout),     32'd0);
        chk("ill_invokes",     32'(inv_cnt - base),  32'd2);
        run = 1'b0;
        step(2);
        chk("ill_sticky",      32'(err_mode), 32'd1);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("ill_cleared",     32'(err_mode), 32'd0);

        // timeout: actor never answers
        actor_on = 1'b0;
        fire_limit = 16'd0;
        run = 1'b1;
        base = inv_cnt;
        wait_invoke("to", 10);
        step(TO);
        chk("to_not_yet",    32'(err_timeout), 32'd0);
        chk("to_busy_wait",  32'(busy),        32'd1);
        step(1);
        chk("to_tripped",    32'(err_timeout), 32'd1);
        chk("to_busy_halt",  32'(busy),        32'd0);
        chk("to_done_halt",  32'(done),        32'd0);
        actor_on = 1'b1;
        run = 1'b0;
        step(3);
        run = 1'b1;
        step(5);
        chk("to_sticky",     32'(err_timeout),    32'd1);
        chk("to_absorbing",  32'(inv_cnt - base), 32'd1);
        run = 1'b0;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("to_cleared",    32'(err_timeout), 32'd0);

        // run dropped during WAIT_FC
        mode_tab[0] = 2'b10; mode_idx = 0;
        a_d = 2; a_h = 1;
        run = 1'b1;
        base = inv_cnt;
        wait_invoke("drop", 10);
        step(1);
        run = 1'b0;
        step(3);
        chk("drop_fire_count", 32'(fire_count), 32'd1);
        chk("drop_next_instr", 32'(next_instr), 32'd2);
        chk("drop_busy_check", 32'(busy),       32'd1);
        step(1);
        chk("drop_idle",       32'(busy),       32'd0);
        step(5);
        chk("drop_no_more",    32'(inv_cnt - base), 32'd1);

        // reset asserted mid-WAIT_FC
        mode_tab[0] = 2'b01; mode_idx = 0;
        run = 1'b1;
        base = inv_cnt;
        wait_invoke("mrst", 10);
        step(1);
        rst = 1'b0;
        #1;
        chk_reset_vals("mrst");
        run = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);
        chk("mrst_idle_busy", 32'(busy),           32'd0);
        chk("mrst_no_inv",    32'(inv_cnt - base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
